// File: rtl/cim_pkg.sv
// Layer-dimension constants and shared types for the CNN pipeline blocks.
package cim_pkg;

    localparam int DATATYPE_SIZE  = 2;
    localparam int INPUT_CHANNELS = 5;
    localparam int OUT_WIDTH      = 12;
    localparam int FRAME_SIZE     = INPUT_CHANNELS * OUT_WIDTH * OUT_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERIAL = 2'd1,
        START  = 2'd2
    } state_t;

    // Counter width that stays at least one bit for degenerate sizes of 1.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/pool_fc_flatten.sv
// Serialises pooled pixel vectors into the fc input buffer in channel-major
// order and pulses the fc start once a full frame has been written.
module pool_fc_flatten
    import cim_pkg::*;
#(
    parameter int datatype_size  = DATATYPE_SIZE,
    parameter int input_channels = INPUT_CHANNELS,
    parameter int out_width      = OUT_WIDTH,
    parameter int frame_size     = input_channels * out_width * out_width,
    parameter int addr_width     = clog2_min1(frame_size)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          i_valid,
    input  logic [input_channels-1:0][datatype_size-1:0]  i_data,
    output logic                                          o_busy,
    output logic                                          o_ibuf_we,
    output logic [datatype_size-1:0]                      o_ibuf_wr_data,
    output logic [addr_width-1:0]                         o_ibuf_addr,
    input  logic                                          i_fc_busy,
    output logic                                          o_start
);

    localparam int pixels = out_width * out_width;
    localparam int ch_w   = clog2_min1(input_channels);
    localparam int pix_w  = clog2_min1(pixels);

    localparam logic [ch_w-1:0]       ch_last  = ch_w'(input_channels - 1);
    localparam logic [pix_w-1:0]      pix_last = pix_w'(pixels - 1);
    localparam logic [addr_width-1:0] stride   = addr_width'(pixels);

    state_t                                      state_reg;
    logic [ch_w-1:0]                             ch_reg;
    logic [pix_w-1:0]                            pix_reg;
    logic [input_channels-1:0][datatype_size-1:0] vec_reg;
    logic [ch_w-1:0]                             ch_next;

    assign ch_next = ch_reg + ch_w'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            ch_reg         <= '0;
            pix_reg        <= '0;
            vec_reg        <= '0;
            o_busy         <= 1'b0;
            o_ibuf_we      <= 1'b0;
            o_ibuf_wr_data <= '0;
            o_ibuf_addr    <= '0;
            o_start        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    o_start <= 1'b0;
                    if (i_valid) begin
                        // Word 0 goes out on the very next cycle straight from i_data.
                        vec_reg        <= i_data;
                        ch_reg         <= '0;
                        state_reg      <= SERIAL;
                        o_busy         <= 1'b1;
                        o_ibuf_we      <= 1'b1;
                        o_ibuf_wr_data <= i_data[0];
                        o_ibuf_addr    <= addr_width'(pix_reg);
                    end
                end

                SERIAL: begin
                    if (ch_reg == ch_last) begin
                        o_ibuf_we      <= 1'b0;
                        o_ibuf_wr_data <= '0;
                        o_ibuf_addr    <= '0;
                        if (pix_reg == pix_last) begin
                            pix_reg   <= '0;
                            state_reg <= START;
                            o_busy    <= 1'b1;
                            o_start   <= ~i_fc_busy;
                        end else begin
                            pix_reg   <= pix_reg + pix_w'(1);
                            state_reg <= IDLE;
                            o_busy    <= 1'b0;
                        end
                    end else begin
                        ch_reg         <= ch_next;
                        o_ibuf_wr_data <= vec_reg[ch_next];
                        o_ibuf_addr    <= o_ibuf_addr + stride;
                    end
                end

                START: begin
                    // o_start high means the pulse is already on the wire this cycle.
                    if (o_start) begin
                        o_start   <= 1'b0;
                        o_busy    <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        o_start <= ~i_fc_busy;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    o_busy    <= 1'b0;
                    o_ibuf_we <= 1'b0;
                    o_start   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool_fc_flatten.sv
// Directed bench for pool_fc_flatten: vector table plus frame-level sequences.
module tb_pool_fc_flatten;

    localparam int DW = 2;
    localparam int C  = 5;
    localparam int OW = 12;
    localparam int P  = OW * OW;
    localparam int F  = C * P;
    localparam int AW = 10;

    typedef logic [C-1:0][DW-1:0] vec_t;

    typedef struct packed {
        vec_t                w;
        logic [C-1:0][AW-1:0] a;
        logic                poke;
    } row_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    vec_t          i_data = '0;
    logic          i_fc_busy = 1'b0;
    logic          o_busy;
    logic          o_ibuf_we;
    logic [DW-1:0] o_ibuf_wr_data;
    logic [AW-1:0] o_ibuf_addr;
    logic          o_start;

    pool_fc_flatten #(
        .datatype_size (DW),
        .input_channels(C),
        .out_width     (OW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .o_busy        (o_busy),
        .o_ibuf_we     (o_ibuf_we),
        .o_ibuf_wr_data(o_ibuf_wr_data),
        .o_ibuf_addr   (o_ibuf_addr),
        .i_fc_busy     (i_fc_busy),
        .o_start       (o_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write scoreboard, sampled on the falling edge.
    logic          clr = 1'b0;
    int            hits [F];
    logic [DW-1:0] mem [F];
    int            wr_count, start_count, oob, last_wr_cyc;

    always @(negedge clk) begin
        if (clr) begin
            for (int i = 0; i < F; i++) begin
                hits[i] = 0;
                mem[i]  = '0;
            end
            wr_count = 0; start_count = 0; oob = 0; last_wr_cyc = 0;
        end else begin
            if (o_ibuf_we === 1'b1) begin
                if (int'(o_ibuf_addr) < F) begin
                    hits[o_ibuf_addr] = hits[o_ibuf_addr] + 1;
                    mem[o_ibuf_addr]  = o_ibuf_wr_data;
                end else begin
                    oob = oob + 1;
                end
                wr_count    = wr_count + 1;
                last_wr_cyc = cyc;
            end
            if (o_start === 1'b1) start_count = start_count + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int p, input int k);
        return DW'((p * 3 + k * 7 + (p >> 3)) & 3);
    endfunction

    function automatic vec_t pat_vec(input int p);
        vec_t v;
        for (int k = 0; k < C; k++) v[k] = pat(p, k);
        return v;
    endfunction

    function automatic row_t mk(input int w0, w1, w2, w3, w4,
                                input int a0, a1, a2, a3, a4, input bit poke);
        row_t r;
        r.w[0] = DW'(w0); r.w[1] = DW'(w1); r.w[2] = DW'(w2); r.w[3] = DW'(w3); r.w[4] = DW'(w4);
        r.a[0] = AW'(a0); r.a[1] = AW'(a1); r.a[2] = AW'(a2); r.a[3] = AW'(a3); r.a[4] = AW'(a4);
        r.poke = poke;
        return r;
    endfunction

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (o_busy !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (o_busy !== 1'b0) check("busy_timeout", o_busy, 0);
    endtask

    task automatic send_quick(input vec_t d);
        wait_idle();
        i_valid = 1'b1;
        i_data  = d;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic send_checked(input int idx, input row_t r);
        wait_idle();
        i_valid = 1'b1;
        i_data  = r.w;
        @(negedge clk);
        i_valid = 1'b0;
        for (int k = 0; k < C; k++) begin
            check($sformatf("v%0d_we%0d", idx, k), o_ibuf_we, 1);
            check($sformatf("v%0d_addr%0d", idx, k), o_ibuf_addr, r.a[k]);
            check($sformatf("v%0d_data%0d", idx, k), o_ibuf_wr_data, r.w[k]);
            check($sformatf("v%0d_busy%0d", idx, k), o_busy, 1);
            $display("vec %0d word %0d addr=%0d data=%0d", idx, k, o_ibuf_addr, o_ibuf_wr_data);
            if (r.poke && k == 1) begin
                i_valid = 1'b1;
                i_data  = ~r.w;
            end
            @(negedge clk);
            i_valid = 1'b0;
        end
        check($sformatf("v%0d_bubble_we", idx), o_ibuf_we, 0);
        check($sformatf("v%0d_bubble_busy", idx), o_busy, 0);
    endtask

    task automatic clear_board();
        @(posedge clk);
        clr = 1'b1;
        @(posedge clk);
        clr = 1'b0;
    endtask

    task automatic verify_frame(input string tag);
        int cover_bad = 0;
        int data_bad = 0;
        for (int a = 0; a < F; a++) begin
            if (hits[a] != 1) cover_bad++;
            else if (mem[a] !== pat(a % P, a / P)) data_bad++;
        end
        check({tag, "_writes"}, wr_count, F);
        check({tag, "_cover"}, cover_bad, 0);
        check({tag, "_data"}, data_bad, 0);
        check({tag, "_oob"}, oob, 0);
        check({tag, "_starts"}, start_count, 1);
        $display("frame %s writes=%0d starts=%0d", tag, wr_count, start_count);
    endtask

    task automatic frame_with_start_timing(input string tag);
        int t = 0;
        for (int p = 0; p < P; p++) send_quick(pat_vec(p));
        while (o_start !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_start_seen"}, o_start, 1);
        check({tag, "_start_cycle"}, cyc, last_wr_cyc + 1);
        repeat (3) @(negedge clk);
        verify_frame(tag);
    endtask

    row_t tbl [4];

    initial begin
        tbl[0] = mk(3, 2, 1, 0, 3, 0, 144, 288, 432, 576, 0);
        tbl[1] = mk(1, 1, 2, 3, 0, 1, 145, 289, 433, 577, 0);
        tbl[2] = mk(0, 3, 3, 1, 2, 2, 146, 290, 434, 578, 1);
        tbl[3] = mk(2, 0, 1, 3, 1, 3, 147, 291, 435, 579, 0);

        // Reset with random inputs: all outputs must stay 0.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_outputs%0d", i),
                  {o_busy, o_ibuf_we, o_ibuf_wr_data, o_ibuf_addr, o_start}, 0);
            $display("reset cycle %0d busy=%0d we=%0d start=%0d", i, o_busy, o_ibuf_we, o_start);
            i_valid   = 1'($urandom);
            i_data    = vec_t'($urandom);
            i_fc_busy = 1'($urandom);
        end
        rst = 1'b0; i_valid = 1'b0; i_fc_busy = 1'b0;

        // Single vectors at pixels 0..3; row 2 also strobes i_valid mid-SERIAL.
        for (int i = 0; i < 4; i++) send_checked(i, tbl[i]);

        // Full frame from pixel 0.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        clear_board();
        frame_with_start_timing("full");

        // Start hold-off while the fc layer is busy.
        clear_board();
        for (int p = 0; p < P - 1; p++) send_quick(pat_vec(p));
        i_fc_busy = 1'b1;
        send_quick(pat_vec(P - 1));
        repeat (C) @(negedge clk);
        for (int h = 0; h < 10; h++) begin
            check($sformatf("hold%0d_busy", h), o_busy, 1);
            check($sformatf("hold%0d_start", h), o_start, 0);
            $display("hold cycle %0d busy=%0d start=%0d", h, o_busy, o_start);
            i_valid = (h == 3);
            i_data  = pat_vec(7);
            if (h == 9) i_fc_busy = 1'b0;
            @(negedge clk);
        end
        i_valid = 1'b0;
        check("hold_release_start", o_start, 1);
        @(negedge clk);
        check("hold_after_start", o_start, 0);
        check("hold_after_busy", o_busy, 0);
        repeat (3) @(negedge clk);
        verify_frame("hold");

        // Reset at the third write of pixel 70, with a simultaneous i_valid.
        for (int p = 0; p < 70; p++) send_quick(pat_vec(p));
        send_quick(pat_vec(70));
        repeat (2) @(negedge clk);
        check("mid_third_write_addr", o_ibuf_addr, 2 * P + 70);
        rst = 1'b1; i_valid = 1'b1; i_data = pat_vec(5);
        @(negedge clk);
        check("mid_reset_outputs", {o_busy, o_ibuf_we, o_ibuf_wr_data, o_ibuf_addr, o_start}, 0);
        rst = 1'b0; i_valid = 1'b0;
        @(negedge clk);
        check("mid_reset_no_capture", o_ibuf_we, 0);
        $display("mid-frame reset applied, we=%0d busy=%0d", o_ibuf_we, o_busy);
        clear_board();
        frame_with_start_timing("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
